// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the UART TX FIFO write port.
// Packets never interleave; grants end on req_last, MAX_PKT_LEN or a stall timeout.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int MAX_PKT_LEN   = 64,
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             tx_fifo_data_in,
    output logic                   tx_fifo_write_en,
    input  logic                   tx_fifo_full,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic                   pkt_done,
    output logic                   pkt_truncated,
    output logic                   pkt_aborted
);

    // state | meaning
    // ------+---------------------------------------------------------
    // IDLE  | no owner; pick next valid requester after rr_ptr
    // GRANT | grant_q owns the FIFO until last/truncate/stall timeout

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_chk_num_req
        $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
    end
    if (MAX_PKT_LEN < 1 || MAX_PKT_LEN > 65535) begin : g_chk_max_pkt
        $error("uart_tx_arbiter: MAX_PKT_LEN must be in 1..65535");
    end
    if (STALL_TIMEOUT < 1 || STALL_TIMEOUT > 65535) begin : g_chk_stall
        $error("uart_tx_arbiter: STALL_TIMEOUT must be in 1..65535");
    end

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]        gidx_q, gidx_d;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [15:0]          byte_cnt_q, byte_cnt_d;
    logic [15:0]          stall_cnt_q, stall_cnt_d;

    logic [7:0]           req_bytes [NUM_REQ];
    logic                 found;
    logic [IW-1:0]        sel;
    logic [IW-1:0]        cand;
    logic                 transfer;
    logic                 release_grant;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_bytes[i] = req_data[8*i +: 8];
    end

    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        gidx_d           = gidx_q;
        rr_ptr_d         = rr_ptr_q;
        byte_cnt_d       = byte_cnt_q;
        stall_cnt_d      = stall_cnt_q;
        req_ready        = '0;
        tx_fifo_write_en = 1'b0;
        tx_fifo_data_in  = '0;
        pkt_done         = 1'b0;
        pkt_truncated    = 1'b0;
        pkt_aborted      = 1'b0;
        found            = 1'b0;
        sel              = '0;
        cand             = '0;
        transfer         = 1'b0;
        release_grant    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Search starts just past the last owner, so it is served last.
                for (int k = 1; k <= NUM_REQ; k++) begin
                    cand = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
                    if (!found && req_valid[cand]) begin
                        found = 1'b1;
                        sel   = cand;
                    end
                end
                if (found) begin
                    grant_d      = '0;
                    grant_d[sel] = 1'b1;
                    gidx_d       = sel;
                    byte_cnt_d   = '0;
                    stall_cnt_d  = '0;
                    state_d      = S_GRANT;
                end
            end
            S_GRANT: begin
                transfer = req_valid[gidx_q] && !tx_fifo_full;
                if (transfer) begin
                    req_ready[gidx_q] = 1'b1;
                    tx_fifo_write_en  = 1'b1;
                    tx_fifo_data_in   = req_bytes[gidx_q];
                    if (req_last[gidx_q]) begin
                        pkt_done      = 1'b1;
                        release_grant = 1'b1;
                    end else if (byte_cnt_q == 16'(MAX_PKT_LEN - 1)) begin
                        pkt_truncated = 1'b1;
                        release_grant = 1'b1;
                    end else begin
                        byte_cnt_d  = byte_cnt_q + 16'd1;
                        stall_cnt_d = '0;
                    end
                end else if (!req_valid[gidx_q] && !tx_fifo_full) begin
                    if (stall_cnt_q == 16'(STALL_TIMEOUT - 1)) begin
                        pkt_aborted   = 1'b1;
                        release_grant = 1'b1;
                    end else begin
                        stall_cnt_d = stall_cnt_q + 16'd1;
                    end
                end
                // A full FIFO is backpressure: the stall counter simply holds.
                if (release_grant) begin
                    state_d  = S_IDLE;
                    grant_d  = '0;
                    rr_ptr_d = gidx_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            gidx_q      <= '0;
            rr_ptr_q    <= IW'(NUM_REQ - 1);
            byte_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            gidx_q      <= gidx_d;
            rr_ptr_q    <= rr_ptr_d;
            byte_cnt_q  <= byte_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q == S_GRANT);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (4 requesters, MAX_PKT_LEN=4, STALL_TIMEOUT=1024).
module tb_uart_tx_arbiter;

    logic        clock;
    logic        reset;
    logic [31:0] req_data;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  tx_fifo_data_in;
    logic        tx_fifo_write_en;
    logic        tx_fifo_full;
    logic [3:0]  grant;
    logic        busy;
    logic        pkt_done;
    logic        pkt_truncated;
    logic        pkt_aborted;

    int n_checks = 0;
    int n_pass   = 0;
    int bad;

    uart_tx_arbiter #(
        .NUM_REQ      (4),
        .MAX_PKT_LEN  (4),
        .STALL_TIMEOUT(1024)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .req_data        (req_data),
        .req_valid       (req_valid),
        .req_last        (req_last),
        .req_ready       (req_ready),
        .tx_fifo_data_in (tx_fifo_data_in),
        .tx_fifo_write_en(tx_fifo_write_en),
        .tx_fifo_full    (tx_fifo_full),
        .grant           (grant),
        .busy            (busy),
        .pkt_done        (pkt_done),
        .pkt_truncated   (pkt_truncated),
        .pkt_aborted     (pkt_aborted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_byte(input int i, input logic [7:0] b);
        req_data[8*i +: 8] = b;
    endtask

    task automatic idle_chk(input string tag);
        #1;
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_grant"}, 32'(grant), 0);
        chk({tag, "_wen"},   32'(tx_fifo_write_en), 0);
        chk({tag, "_ready"}, 32'(req_ready), 0);
        chk({tag, "_pulse"}, 32'({pkt_done, pkt_truncated, pkt_aborted}), 0);
    endtask

    task automatic xfer(input string tag, input logic [3:0] g, input logic [7:0] d,
                        input logic done, input logic trunc);
        #1;
        chk({tag, "_grant"}, 32'(grant), 32'(g));
        chk({tag, "_wen"},   32'(tx_fifo_write_en), 1);
        chk({tag, "_data"},  32'(tx_fifo_data_in), 32'(d));
        chk({tag, "_ready"}, 32'(req_ready), 32'(g));
        chk({tag, "_done"},  32'(pkt_done), 32'(done));
        chk({tag, "_trunc"}, 32'(pkt_truncated), 32'(trunc));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b0;
        req_data     = '0;
        req_valid    = '0;
        req_last     = '0;
        tx_fifo_full = 1'b0;
        #2;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_wen",   32'(tx_fifo_write_en), 0);
        chk("rst_data",  32'(tx_fifo_data_in), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_pulse", 32'({pkt_done, pkt_truncated, pkt_aborted}), 0);
        #10;
        reset = 1'b1;
        tick();

        // single packet from requester 2
        req_valid[2] = 1'b1; set_byte(2, 8'h41);
        idle_chk("s_arb");
        tick(); xfer("s_b1", 4'b0100, 8'h41, 0, 0);
        tick(); set_byte(2, 8'h42); xfer("s_b2", 4'b0100, 8'h42, 0, 0);
        tick(); set_byte(2, 8'h43); req_last[2] = 1'b1; xfer("s_b3", 4'b0100, 8'h43, 1, 0);
        tick(); req_valid = '0; req_last = '0; idle_chk("s_end");

        reset = 1'b0;
        tick();
        reset = 1'b1;

        // round robin over 0,1,3 then 0 again
        req_valid = 4'b1011;
        set_byte(0, 8'h10); set_byte(1, 8'h20); set_byte(3, 8'h30);
        idle_chk("rr_arb0");
        tick(); xfer("rr_p0b1", 4'b0001, 8'h10, 0, 0);
        tick(); set_byte(0, 8'h11); req_last[0] = 1'b1; xfer("rr_p0b2", 4'b0001, 8'h11, 1, 0);
        tick(); req_valid[0] = 1'b0; req_last[0] = 1'b0; idle_chk("rr_arb1");
        tick(); xfer("rr_p1b1", 4'b0010, 8'h20, 0, 0);
        tick(); set_byte(1, 8'h21); req_last[1] = 1'b1; xfer("rr_p1b2", 4'b0010, 8'h21, 1, 0);
        tick(); req_valid[1] = 1'b0; req_last[1] = 1'b0;
        req_valid[0] = 1'b1; set_byte(0, 8'h12); req_last[0] = 1'b1;
        idle_chk("rr_arb3");
        tick(); xfer("rr_p3b1", 4'b1000, 8'h30, 0, 0);
        tick(); set_byte(3, 8'h31); req_last[3] = 1'b1; xfer("rr_p3b2", 4'b1000, 8'h31, 1, 0);
        tick(); req_valid[3] = 1'b0; req_last[3] = 1'b0; idle_chk("rr_arb0b");
        tick(); xfer("rr_p0again", 4'b0001, 8'h12, 1, 0);
        tick(); req_valid = '0; req_last = '0; idle_chk("rr_end");

        // backpressure during requester 1's 4-byte packet
        tick();
        req_valid[1] = 1'b1; set_byte(1, 8'h51);
        idle_chk("bp_arb");
        tick(); xfer("bp_b1", 4'b0010, 8'h51, 0, 0);
        tick(); set_byte(1, 8'h52); xfer("bp_b2", 4'b0010, 8'h52, 0, 0);
        tick(); set_byte(1, 8'h53); tx_fifo_full = 1'b1;
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            req_valid[1] = (i >= 1500);
            #1;
            if (tx_fifo_write_en || req_ready != 4'b0000 || pkt_aborted || grant != 4'b0010)
                bad++;
            tick();
        end
        chk("bp_window_viol", 32'(bad), 0);
        tx_fifo_full = 1'b0; req_valid[1] = 1'b1;
        xfer("bp_b3", 4'b0010, 8'h53, 0, 0);
        tick(); set_byte(1, 8'h54); req_last[1] = 1'b1; xfer("bp_b4", 4'b0010, 8'h54, 1, 0);
        tick(); req_valid = '0; req_last = '0; idle_chk("bp_end");

        // stall timeout on requester 0 with requester 2 pending
        tick();
        req_valid[0] = 1'b1; set_byte(0, 8'h61);
        idle_chk("st_arb");
        tick(); xfer("st_b1", 4'b0001, 8'h61, 0, 0);
        tick(); req_valid[0] = 1'b0; req_valid[2] = 1'b1; set_byte(2, 8'h71);
        bad = 0;
        for (int i = 1; i < 1024; i++) begin
            #1;
            if (pkt_aborted || grant != 4'b0001 || tx_fifo_write_en) bad++;
            tick();
        end
        chk("st_early_viol", 32'(bad), 0);
        #1;
        chk("st_abort", 32'(pkt_aborted), 1);
        chk("st_abort_grant", 32'(grant), 32'(4'b0001));
        tick(); req_last[2] = 1'b1; idle_chk("st_idle");
        tick(); xfer("st_req2", 4'b0100, 8'h71, 1, 0);
        tick(); req_valid = '0; req_last = '0; idle_chk("st_end");

        // truncation at MAX_PKT_LEN=4, requester 1 served in between
        tick();
        req_valid[3] = 1'b1; set_byte(3, 8'h81);
        req_valid[1] = 1'b1; set_byte(1, 8'h91); req_last[1] = 1'b1;
        idle_chk("tr_arb");
        tick(); xfer("tr_b1", 4'b1000, 8'h81, 0, 0);
        tick(); set_byte(3, 8'h82); xfer("tr_b2", 4'b1000, 8'h82, 0, 0);
        tick(); set_byte(3, 8'h83); xfer("tr_b3", 4'b1000, 8'h83, 0, 0);
        tick(); set_byte(3, 8'h84); xfer("tr_b4", 4'b1000, 8'h84, 0, 1);
        tick(); set_byte(3, 8'h85); idle_chk("tr_rel");
        tick(); xfer("tr_req1", 4'b0010, 8'h91, 1, 0);
        tick(); req_valid[1] = 1'b0; req_last[1] = 1'b0; idle_chk("tr_arb3");
        tick(); xfer("tr_b5", 4'b1000, 8'h85, 0, 0);
        tick(); set_byte(3, 8'h86); req_last[3] = 1'b1; xfer("tr_b6", 4'b1000, 8'h86, 1, 0);
        tick(); req_valid = '0; req_last = '0; idle_chk("tr_end");

        // async reset in the middle of requester 2's 5-byte packet
        tick();
        req_valid[1] = 1'b1; set_byte(1, 8'hA0); req_last[1] = 1'b1;
        idle_chk("ar_arb1");
        tick(); xfer("ar_p1", 4'b0010, 8'hA0, 1, 0);
        tick(); req_valid[1] = 1'b0; req_last[1] = 1'b0;
        req_valid[2] = 1'b1; set_byte(2, 8'hB1);
        idle_chk("ar_arb2");
        tick(); xfer("ar_b1", 4'b0100, 8'hB1, 0, 0);
        tick(); set_byte(2, 8'hB2); xfer("ar_b2", 4'b0100, 8'hB2, 0, 0);
        tick(); set_byte(2, 8'hB3);
        #1;
        chk("ar_pre_wen", 32'(tx_fifo_write_en), 1);
        reset = 1'b0;
        #1;
        chk("ar_grant", 32'(grant), 0);
        chk("ar_wen",   32'(tx_fifo_write_en), 0);
        chk("ar_ready", 32'(req_ready), 0);
        chk("ar_busy",  32'(busy), 0);
        chk("ar_data",  32'(tx_fifo_data_in), 0);
        req_valid[0] = 1'b1; set_byte(0, 8'h01); req_last[0] = 1'b1;
        tick();
        reset = 1'b1;
        idle_chk("ar_rearb");
        tick(); xfer("ar_restart0", 4'b0001, 8'h01, 1, 0);
        tick(); req_valid = '0; req_last = '0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single UART TX FIFO write port among NUM_REQ byte-stream requesters.
- Sits between the command/response producers and the uart block's tx_fifo_data_in / tx_fifo_write_en / tx_fifo_full interface.
- Guarantees packets from different requesters never interleave.
- Bounds packet length and releases a grant held by a stalled requester.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_PKT_LEN, 64, maximum bytes per grant; the grant is force-released after this many bytes.
- STALL_TIMEOUT, 1024, number of consecutive idle cycles (requester not valid, FIFO not full) before the grant is revoked.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- req_data  in  8*NUM_REQ  byte from requester i on bits [8i+7:8i].
- req_valid  in  NUM_REQ  requester i presents a byte.
- req_last  in  NUM_REQ  byte from requester i is the final byte of its packet.
- req_ready  out  NUM_REQ  byte from requester i accepted this cycle (combinational).
- tx_fifo_data_in  out  8  byte to the UART TX FIFO.
- tx_fifo_write_en  out  1  write strobe to the UART TX FIFO.
- tx_fifo_full  in  1  UART TX FIFO full.
- grant  out  NUM_REQ  one-hot owner of the FIFO; all zero when idle (registered).
- busy  out  1  high while in the GRANT state.
- pkt_done  out  1  one-cycle pulse when a packet ends with req_last.
- pkt_truncated  out  1  one-cycle pulse when a grant is released at MAX_PKT_LEN without req_last.
- pkt_aborted  out  1  one-cycle pulse when a grant is revoked by STALL_TIMEOUT.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, grant=0, rr_ptr=NUM_REQ-1, byte_cnt=0, stall_cnt=0.
  - All pulses 0; req_ready=0, tx_fifo_write_en=0, tx_fifo_data_in=0.
  - A reset mid-packet discards the grant; the remainder of that packet is not sent.
- State IDLE:
  - If any req_valid is set, select the first set bit searching (rr_ptr+1) mod NUM_REQ upward with wrap-around.
  - Register the selection into grant, clear byte_cnt and stall_cnt, and go to GRANT.
  - No byte is accepted in IDLE, so arbitration costs one cycle.
- State GRANT, with g = the granted index:
  - transfer = req_valid[g] && !tx_fifo_full.
  - req_ready[g] = transfer; all other req_ready bits are 0.
  - tx_fifo_write_en = transfer and tx_fifo_data_in = req_data[g], both combinational with zero latency. When write_en=0, tx_fifo_data_in=0.
- Transfer handling (all cases return to IDLE with grant<=0 and rr_ptr<=g, except the plain-byte case):
  - transfer && req_last[g]: pulse pkt_done.
  - transfer && !req_last[g] && byte_cnt==MAX_PKT_LEN-1: pulse pkt_truncated. The requester's remaining bytes form a new packet on its next grant.
  - Any other transfer: byte_cnt++, stall_cnt<=0.
  - If req_last coincides with the MAX_PKT_LEN boundary, this counts as pkt_done, not truncated.
- Stall handling:
  - !req_valid[g] && !tx_fifo_full: stall_cnt++.
  - When stall_cnt==STALL_TIMEOUT-1 on such a cycle: pulse pkt_aborted, grant<=0, rr_ptr<=g, go to IDLE.
- tx_fifo_full held high: stall_cnt holds. This is backpressure, not a requester stall, so the grant is never revoked.
- Fairness: after g finishes, every other valid requester is served once before g is served again.
- A single requester can re-win immediately after one IDLE cycle.
- Requests for the same index in consecutive packets lose exactly one cycle per packet.
- Counters are 16 bits wide. MAX_PKT_LEN and STALL_TIMEOUT must be ≤ 65535; violations are an elaboration error.
- Invariants: grant is one-hot or zero, and busy == (grant != 0).

Test Plan:
- Single packet: req 2 sends bytes 0x41,0x42,0x43 (last on 0x43) with full=0.
  - IDLE→GRANT takes 1 cycle; 3 consecutive write_en pulses carry 0x41,0x42,0x43.
  - pkt_done pulses on the 0x43 cycle; grant returns to 0.
- Round-robin: reqs 0,1,3 each hold a 2-byte packet valid from reset.
  - Grant order is 0,1,3, then 0 again if re-requested.
  - The FIFO byte stream is never interleaved; rr_ptr ends at 3.
- Backpressure: during req 1's 4-byte packet, tx_fifo_full is held high for 2000 cycles after byte 2.
  - No writes occur and req_ready[1]=0 for the whole window.
  - No pkt_aborted; bytes 3-4 follow once full drops.
- Stall timeout: req 0 sends 1 byte, then deasserts valid with full=0.
  - Exactly 1024 cycles later pkt_aborted pulses and grant=0.
  - A pending req 2 is granted on the next IDLE cycle.
- Truncation: with MAX_PKT_LEN=4, req 3 sends 6 bytes, last on byte 6.
  - pkt_truncated pulses after byte 4; req 3 is re-granted after other requesters.
  - Bytes 5-6 are then sent and followed by pkt_done.
- Async reset mid-packet: drop reset after byte 2 of a 5-byte packet.
  - grant, write_en and req_ready go to 0 immediately without waiting for a clock edge.
  - After release, arbitration restarts from requester 0.
